// File: rtl/dma_priority_arbiter.sv
// Channel request/acknowledge controller for an 8237A-style DMA: DREQ sync, mask/software
// requests, HRQ/HLDA bus handshake, fixed or rotating channel priority and DACK drive.
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] MASK,
  input  logic [NUM_CH-1:0] SW_REQ,
  input  logic              CTRL_DISABLE,
  input  logic              ROT_PRI,
  input  logic              DREQ_SENSE_LOW,
  input  logic              DACK_SENSE_HIGH,
  input  logic              XFER_DONE,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        CH_SEL,
  output logic              SVC_VALID
);

  // state   | meaning
  // IDLE    | no request pending, bus not requested
  // REQ     | HRQ raised, waiting for HLDA
  // GRANT   | bus owned, DACK held on the winning channel
  // RELEASE | service done, HRQ dropped, waiting for HLDA to fall
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic                              hrq_q, hrq_d;
  logic [NUM_CH-1:0]                 grant_q, grant_d;
  logic [1:0]                        ch_sel_q, ch_sel_d;
  logic                              svc_valid_q, svc_valid_d;
  logic [1:0]                        last_q, last_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;

  logic [NUM_CH-1:0] dreq_in;
  logic [NUM_CH-1:0] dreq_s;
  logic [NUM_CH-1:0] eff_req;
  logic              any_req;
  logic [1:0]        win_ch;
  logic [1:0]        idx;
  logic              win_found;

  // Polarity is normalised before the synchroniser so dreq_s is always active-high.
  always_comb begin
    dreq_in = DREQ ^ {NUM_CH{DREQ_SENSE_LOW}};
    sync_d  = {sync_q[SYNC_STAGES-2:0], dreq_in};
    dreq_s  = sync_q[SYNC_STAGES-1];
    eff_req = CTRL_DISABLE ? '0 : ((dreq_s & ~MASK) | SW_REQ);
    any_req = |eff_req;
  end

  // Priority search starts at ch0 (fixed) or at the channel after the last one served.
  always_comb begin
    win_ch    = 2'd0;
    win_found = 1'b0;
    idx       = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ROT_PRI ? (last_q + 2'(i) + 2'd1) : 2'(i);
      if (!win_found && eff_req[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hrq_d       = hrq_q;
    grant_d     = grant_q;
    ch_sel_d    = ch_sel_q;
    svc_valid_d = svc_valid_q;
    last_d      = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_REQ;
          hrq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (!any_req) begin
          state_d = ST_IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA) begin
          state_d     = ST_GRANT;
          grant_d     = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch;
          ch_sel_d    = win_ch;
          svc_valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        // Completion wins over a simultaneous HLDA drop so the pointer still rotates.
        if (XFER_DONE) begin
          state_d     = ST_RELEASE;
          last_d      = ch_sel_q;
          hrq_d       = 1'b0;
          grant_d     = '0;
          svc_valid_d = 1'b0;
        end else if (!HLDA) begin
          state_d     = ST_IDLE;
          hrq_d       = 1'b0;
          grant_d     = '0;
          svc_valid_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (!HLDA) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        hrq_d       = 1'b0;
        grant_d     = '0;
        svc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      hrq_q       <= 1'b0;
      grant_q     <= '0;
      ch_sel_q    <= 2'd0;
      svc_valid_q <= 1'b0;
      last_q      <= 2'd3;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      hrq_q       <= hrq_d;
      grant_q     <= grant_d;
      ch_sel_q    <= ch_sel_d;
      svc_valid_q <= svc_valid_d;
      last_q      <= last_d;
      sync_q      <= sync_d;
    end
  end

  assign HRQ       = hrq_q;
  assign DACK      = DACK_SENSE_HIGH ? grant_q : ~grant_q;
  assign CH_SEL    = ch_sel_q;
  assign SVC_VALID = svc_valid_q;

endmodule
